onoff_cmd_gen: RTL

- Upstream command stage for the two-state on/off Moore FSM (inputs j/k, output out).
- Converts raw, asynchronous, bouncing push-buttons (btn_on, btn_off) into clean single-cycle j/k command pulses.
- Each button is synchronised, debounced by a stable-count state machine, and edge-detected; a priority rule resolves simultaneous presses.
- j/k drive the FSM directly on the same clk.

---
 rtl/onoff_pkg.sv | 16 +
 rtl/btn_debounce.sv | 115 +++++++++++
 rtl/onoff_cmd_gen.sv | 89 ++++++++
 3 files changed

// File: rtl/onoff_pkg.sv
// onoff_pkg: shared definitions for the on/off command generator.
// Holds the debouncer state encoding and the default debounce length.
package onoff_pkg;

    // Debouncer states: two settled levels, each with a checking state on the way out
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } deb_state_t;

    // Consecutive synchronised-stable cycles needed to accept a level change
    localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser plus stable-count debouncer for one raw button.
// level is the accepted button state. rise is a combinational strobe that is high in
// the cycle before level goes high; the parent registers it, so the registered pulse
// and the level change appear on the same clock edge.
module btn_debounce
    import onoff_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    // cnt holds the stable samples already seen in a CHK state; the sample taken at the
    // edge where cnt equals CNT_LAST is the DEBOUNCE_CYCLES-th one, so the change is
    // accepted on that edge. cnt never exceeds CNT_LAST and therefore never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_q;
    logic             s;
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Two-flop synchroniser; nothing else looks at the raw input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_q <= raw;
            s      <= sync_q;
        end
    end

    // State and stable-count registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE_LO;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: start checking on a change, reject glitches, accept after enough stable samples
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE_LO: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = IDLE_HI;
                        cnt_next   = '0;
                    end else begin
                        state_next = CHK_HI;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = IDLE_LO;
                        cnt_next   = '0;
                    end else begin
                        state_next = CHK_LO;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_next = IDLE_HI;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LO;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs: level follows the settled side; rise fires only when a press is accepted
    always_comb begin
        level = (state == IDLE_HI) || (state == CHK_LO);
        rise  = !level && (state_next == IDLE_HI);
    end

endmodule

// File: rtl/onoff_cmd_gen.sv
// onoff_cmd_gen: turns raw on/off push-buttons into clean one-cycle j/k commands for
// the on/off Moore FSM. Simultaneous on and off presses resolve to off (safe state).
// Optional feature macro: ONOFF_TOGGLE_EN adds a toggle button that pulses j and k together.
module onoff_cmd_gen
    import onoff_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_on,
    input  logic btn_off,
`ifdef ONOFF_TOGGLE_EN
    input  logic btn_tog,
    output logic tog_lvl,
`endif
    output logic j,
    output logic k,
    output logic on_lvl,
    output logic off_lvl
);

    logic on_rise;
    logic off_rise;
    logic j_next;
    logic k_next;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_on (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (btn_on),
        .level  (on_lvl),
        .rise   (on_rise)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_off (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (btn_off),
        .level  (off_lvl),
        .rise   (off_rise)
    );

`ifdef ONOFF_TOGGLE_EN
    logic tog_rise;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_tog (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (btn_tog),
        .level  (tog_lvl),
        .rise   (tog_rise)
    );
`endif

    // Command mapping: off beats on; a lone toggle press asks for both j and k
    always_comb begin
        j_next = on_rise & ~off_rise;
        k_next = off_rise;
`ifdef ONOFF_TOGGLE_EN
        if (tog_rise && !on_rise && !off_rise) begin
            j_next = 1'b1;
            k_next = 1'b1;
        end
`endif
    end

    // Registered command outputs, changing on the same edge as the debounced levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            j <= 1'b0;
            k <= 1'b0;
        end else begin
            j <= j_next;
            k <= k_next;
        end
    end

endmodule
